// File: rtl/mem_port_arbiter_pkg.sv
// Shared types for the two-requester memory port arbiter: FSM states,
// requester id and the per-requester request bundle.
package mem_port_arbiter_pkg;

  // Request bundles carry a fixed-width address; the top slices it back down.
  localparam int ADDR_MAX = 32;
  localparam int HOLD_W   = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_OWN0 = 2'd1,
    ST_OWN1 = 2'd2
  } state_t;

  typedef logic req_id_t;

  typedef struct packed {
    logic                write;
    logic [ADDR_MAX-1:0] addr;
    logic [31:0]         wdata;
    logic [3:0]          byteen;
  } req_t;

  function automatic state_t own_state(input req_id_t id);
    return id ? ST_OWN1 : ST_OWN0;
  endfunction

endpackage

// File: rtl/mem_port_arbiter_hold_counter.sv
// Saturating count of consecutive beats granted to the current owner.
// clear starts a new run at one beat; increment extends it up to MAX_HOLD.
module mem_port_arbiter_hold_counter
  import mem_port_arbiter_pkg::*;
#(
  parameter int MAX_HOLD = 8
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  input  logic increment,
  output logic at_limit
);

  localparam logic [HOLD_W-1:0] LIMIT = HOLD_W'(MAX_HOLD);

  logic [HOLD_W-1:0] count;

  // NOTE: sequential state is written with <= so every flop samples pre-edge values.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (clear) begin
      count <= HOLD_W'(1);
    end else if (increment && count != LIMIT) begin
      count <= count + HOLD_W'(1);
    end
  end

  assign at_limit = (count == LIMIT);

endmodule

// File: rtl/mem_port_arbiter.sv
// Two-requester arbiter for a single-ported memory: sticky ownership with a
// bounded hold under contention, plus a one-deep read-return tag.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int ADDR_WIDTH = 12,
  parameter int MAX_HOLD   = 8
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  req0_valid,
  output logic                  req0_ready,
  input  logic                  req0_write,
  input  logic [ADDR_WIDTH-1:0] req0_addr,
  input  logic [31:0]           req0_wdata,
  input  logic [3:0]            req0_byteen,
  output logic                  req0_rvalid,
  output logic [31:0]           req0_rdata,
  input  logic                  req1_valid,
  output logic                  req1_ready,
  input  logic                  req1_write,
  input  logic [ADDR_WIDTH-1:0] req1_addr,
  input  logic [31:0]           req1_wdata,
  input  logic [3:0]            req1_byteen,
  output logic                  req1_rvalid,
  output logic [31:0]           req1_rdata,
  output logic                  mem_en,
  output logic                  mem_write,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [31:0]           mem_wdata,
  output logic [3:0]            mem_byteen,
  input  logic [31:0]           mem_rdata,
  output logic                  owner,
  output logic                  busy
);

  state_t  state, state_next;
  req_id_t sel_id, last_served, tag_id;
  logic    sel_valid, accept, same_owner, at_limit, tag_valid;
  logic [1:0] valid;
  req_t    r0, r1, mem_req;
  logic    unused_addr_bits;

  assign valid = {req1_valid, req0_valid};
  assign r0 = '{write: req0_write, addr: ADDR_MAX'(req0_addr), wdata: req0_wdata, byteen: req0_byteen};
  assign r1 = '{write: req1_write, addr: ADDR_MAX'(req1_addr), wdata: req1_wdata, byteen: req1_byteen};

  // NOTE: reset is asynchronous, so the combinational grant is also masked by it
  // to keep every output at zero while reset is held, independent of the clock.
  assign accept     = sel_valid && !reset;
  assign same_owner = (state == own_state(sel_id));

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_next;
  end

  // An owner keeps the port unless it drops valid or has used up its hold
  // while the other side waits; from IDLE, contention goes to the side not served last.
  always_comb begin
    sel_id    = ~last_served;
    sel_valid = 1'b0;
    case (state)
      ST_OWN0: begin
        sel_id    = (valid[0] && !(at_limit && valid[1])) ? 1'b0 : 1'b1;
        sel_valid = valid[sel_id];
      end
      ST_OWN1: begin
        sel_id    = (valid[1] && !(at_limit && valid[0])) ? 1'b1 : 1'b0;
        sel_valid = valid[sel_id];
      end
      default: begin
        sel_id    = (&valid) ? ~last_served : valid[1];
        sel_valid = |valid;
      end
    endcase
    state_next = (sel_valid && !reset) ? own_state(sel_id) : ST_IDLE;
  end

  always_comb begin
    mem_req     = accept ? (sel_id ? r1 : r0) : '0;
    req0_ready  = accept && !sel_id;
    req1_ready  = accept && sel_id;
    owner       = accept && sel_id;
    busy        = accept;
    mem_en      = accept;
    mem_write   = mem_req.write;
    mem_addr    = mem_req.addr[ADDR_WIDTH-1:0];
    mem_wdata   = mem_req.wdata;
    mem_byteen  = mem_req.byteen;
    req0_rvalid = tag_valid && !tag_id;
    req1_rvalid = tag_valid && tag_id;
    req0_rdata  = req0_rvalid ? mem_rdata : '0;
    req1_rdata  = req1_rvalid ? mem_rdata : '0;
  end

  // Bits above ADDR_WIDTH only exist to fit the fixed-width request bundle.
  assign unused_addr_bits = ^mem_req.addr;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      last_served <= 1'b1;
      tag_valid   <= 1'b0;
      tag_id      <= 1'b0;
    end else begin
      if (accept) last_served <= sel_id;
      tag_valid <= accept && !mem_req.write;
      tag_id    <= sel_id;
    end
  end

  mem_port_arbiter_hold_counter #(
    .MAX_HOLD (MAX_HOLD)
  ) u_hold (
    .clock     (clock),
    .reset     (reset),
    .clear     (accept && !same_owner),
    .increment (accept && same_owner),
    .at_limit  (at_limit)
  );

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed scenarios plus random
// traffic, every cycle compared against a grant/return reference model.
module tb_mem_port_arbiter;

  localparam int AW = 12;
  localparam int MH = 4;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          req0_valid, req0_ready, req0_write, req0_rvalid;
  logic [AW-1:0] req0_addr;
  logic [31:0]   req0_wdata, req0_rdata;
  logic [3:0]    req0_byteen;
  logic          req1_valid, req1_ready, req1_write, req1_rvalid;
  logic [AW-1:0] req1_addr;
  logic [31:0]   req1_wdata, req1_rdata;
  logic [3:0]    req1_byteen;
  logic          mem_en, mem_write, owner, busy;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata, mem_rdata;
  logic [3:0]    mem_byteen;

  always #5 clock = ~clock;

  mem_port_arbiter #(.ADDR_WIDTH(AW), .MAX_HOLD(MH)) dut (
    .clock(clock), .reset(reset),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_write(req0_write),
    .req0_addr(req0_addr), .req0_wdata(req0_wdata), .req0_byteen(req0_byteen),
    .req0_rvalid(req0_rvalid), .req0_rdata(req0_rdata),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_write(req1_write),
    .req1_addr(req1_addr), .req1_wdata(req1_wdata), .req1_byteen(req1_byteen),
    .req1_rvalid(req1_rvalid), .req1_rdata(req1_rdata),
    .mem_en(mem_en), .mem_write(mem_write), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_byteen(mem_byteen), .mem_rdata(mem_rdata),
    .owner(owner), .busy(busy)
  );

  int checks   = 0;
  int failures = 0;

  // Reference model: who owned last cycle, how long its run is, who was
  // served last, and which read is waiting for its data.
  bit m_has_owner, m_owner, m_last, m_pend, m_pend_id;
  int m_run;
  bit last_g, last_gid;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_has_owner = 1'b0;
    m_owner     = 1'b0;
    m_run       = 0;
    m_last      = 1'b1;
    m_pend      = 1'b0;
    m_pend_id   = 1'b0;
  endtask

  // Preferred side: the owner while its run is short, the challenger once the
  // run is full, the side not served last when nobody owns; fall back to the other.
  function automatic void predict(input bit v0, input bit v1, output bit g, output bit gid);
    bit [1:0] vv;
    bit pref;
    vv = {v1, v0};
    if (!m_has_owner)     pref = !m_last;
    else if (m_run < MH)  pref = m_owner;
    else                  pref = !m_owner;
    g   = 1'b1;
    gid = pref;
    if (!vv[pref]) begin
      gid = !pref;
      g   = vv[!pref];
    end
    if (!g) gid = 1'b0;
  endfunction

  task automatic idle_inputs();
    req0_valid = 0; req0_write = 0; req0_addr = '0; req0_wdata = '0; req0_byteen = '0;
    req1_valid = 0; req1_write = 0; req1_addr = '0; req1_wdata = '0; req1_byteen = '0;
  endtask

  task automatic randomize_fields();
    req0_write = 1'($urandom_range(0, 1)); req0_addr = AW'($urandom);
    req0_wdata = $urandom; req0_byteen = 4'($urandom);
    req1_write = 1'($urandom_range(0, 1)); req1_addr = AW'($urandom);
    req1_wdata = $urandom; req1_byteen = 4'($urandom);
    mem_rdata  = $urandom;
  endtask

  // Called #1 after the driving negedge: compare every output, advance the model.
  task automatic step();
    bit g, gid, w;
    predict(req0_valid, req1_valid, g, gid);
    w = gid ? req1_write : req0_write;
    check("ready0", 64'(req0_ready), 64'(g && !gid));
    check("ready1", 64'(req1_ready), 64'(g && gid));
    check("busy", 64'(busy), 64'(g));
    check("owner", 64'(owner), 64'(g && gid));
    check("mem_en", 64'(mem_en), 64'(g));
    check("mem_write", 64'(mem_write), 64'(g && w));
    check("mem_addr", 64'(mem_addr), g ? 64'(gid ? req1_addr : req0_addr) : 64'd0);
    check("mem_wdata", 64'(mem_wdata), g ? 64'(gid ? req1_wdata : req0_wdata) : 64'd0);
    check("mem_byteen", 64'(mem_byteen), g ? 64'(gid ? req1_byteen : req0_byteen) : 64'd0);
    check("rvalid0", 64'(req0_rvalid), 64'(m_pend && !m_pend_id));
    check("rvalid1", 64'(req1_rvalid), 64'(m_pend && m_pend_id));
    check("rdata0", 64'(req0_rdata), (m_pend && !m_pend_id) ? 64'(mem_rdata) : 64'd0);
    check("rdata1", 64'(req1_rdata), (m_pend && m_pend_id) ? 64'(mem_rdata) : 64'd0);
    if (g) begin
      if (m_has_owner && m_owner == gid) m_run = (m_run < MH) ? m_run + 1 : MH;
      else                               m_run = 1;
      m_has_owner = 1'b1;
      m_owner     = gid;
      m_last      = gid;
    end else begin
      m_has_owner = 1'b0;
    end
    m_pend    = g && !w;
    m_pend_id = gid;
    last_g    = g;
    last_gid  = gid;
    @(negedge clock);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_ctl"}, 64'({req0_ready, req1_ready, req0_rvalid, req1_rvalid,
                              mem_en, mem_write, owner, busy, mem_byteen}), 64'd0);
    check({tag, "_addr"}, 64'(mem_addr), 64'd0);
    check({tag, "_data"}, {req0_rdata, req1_rdata}, 64'd0);
    check({tag, "_wdata"}, 64'(mem_wdata), 64'd0);
  endtask

  // Enters from a negedge, holds reset two cycles with live traffic, releases at a negedge.
  task automatic apply_reset();
    reset = 1'b1;
    randomize_fields();
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    #1;
    check_all_zero("rst");
    @(negedge clock);
    @(negedge clock);
    idle_inputs();
    reset = 1'b0;
    model_reset();
  endtask

  initial begin
    int accepts;
    logic [8:0] hold_tab;
    idle_inputs();
    mem_rdata = '0;
    model_reset();
    @(negedge clock);
    apply_reset();

    // Single read from requester 0, data returned the following cycle.
    req0_valid = 1; req0_addr = 'h010; mem_rdata = $urandom;
    #1; check("r34_ready0", 64'(req0_ready), 64'd1);
    step();
    idle_inputs(); mem_rdata = 32'hDEADBEEF;
    #1;
    check("r34_rvalid0", 64'(req0_rvalid), 64'd1);
    check("r34_rdata0", 64'(req0_rdata), 64'hDEADBEEF);
    check("r34_rvalid1", 64'(req1_rvalid), 64'd0);
    step();
    #1; check("r34_rvalid0_once", 64'(req0_rvalid), 64'd0);
    step();

    // Write from requester 1: fields pass through, nothing comes back.
    req1_valid = 1; req1_write = 1; req1_addr = 'h3FF; req1_wdata = 32'h12345678; req1_byteen = 4'b0011;
    #1;
    check("r37_fields", {mem_en, mem_write, 2'b00, mem_addr, mem_byteen, 12'd0, mem_wdata},
          {1'b1, 1'b1, 2'b00, 12'h3FF, 4'b0011, 12'd0, 32'h12345678});
    step();
    idle_inputs();
    #1; check("r37_no_rvalid", 64'({req0_rvalid, req1_rvalid}), 64'd0);
    step();

    // Contention straight out of reset: requester 0 wins first.
    apply_reset();
    for (int i = 0; i < 12; i++) begin
      randomize_fields();
      req0_valid = 1; req1_valid = 1; req0_write = 0; req1_write = 0;
      #1;
      if (i == 0) check("r35_first_owner", 64'({busy, owner}), 64'b10);
      step();
    end
    idle_inputs();
    #1; step();

    // Hold limit: req0 beats 1-4, req1 beats 5-8, req0 again on 9.
    apply_reset();
    hold_tab = 9'b0_1111_0000;
    for (int i = 0; i < 11; i++) begin
      randomize_fields();
      req0_valid = 1;
      req1_valid = (i >= 1 && i < 9);
      #1;
      if (i < 9) check($sformatf("r36_owner%0d", i), 64'({busy, owner}), 64'({1'b1, hold_tab[i]}));
      step();
    end

    // Reset arriving right after a read accept kills the pending return.
    idle_inputs();
    #1; step();
    req0_valid = 1; req0_addr = 'h055;
    #1; check("r38_ready0", 64'(req0_ready), 64'd1);
    @(posedge clock);
    reset = 1'b1;
    #1;
    check_all_zero("r38_during");
    @(negedge clock);
    idle_inputs();
    #1; check_all_zero("r38_hold");
    @(negedge clock);
    reset = 1'b0;
    model_reset();
    mem_rdata = $urandom;
    #1; check("r38_no_rvalid", 64'({req0_rvalid, req1_rvalid}), 64'd0);
    step();
    req0_valid = 1; req1_valid = 1;
    #1; check("r38_idle_after", 64'({busy, owner}), 64'b10);
    step();

    // Lone requester streams without gaps, well past the hold limit.
    apply_reset();
    accepts = 0;
    for (int i = 0; i < 20; i++) begin
      randomize_fields();
      req0_valid = 1;
      #1;
      check($sformatf("r39_beat%0d", i), 64'({busy, owner, req0_ready}), 64'b101);
      step();
      if (last_g && !last_gid) accepts++;
    end
    check("r39_accepts", 64'(accepts), 64'd20);

    // Random traffic against the model.
    idle_inputs();
    #1; step();
    for (int i = 0; i < 400; i++) begin
      randomize_fields();
      req0_valid = ($urandom_range(0, 3) != 0);
      req1_valid = ($urandom_range(0, 2) != 0);
      #1;
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "bench did not finish");
  end

endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 12, word-address width of the shared memory port.
REQ-002 SHALL have parameter MAX_HOLD, default 8, the most consecutive accepted beats one owner may take while the other requester waits (range 1..255).
REQ-003 SHALL have port clock, input, 1, the single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-005 SHALL have, for each requester N in {0,1}, the ports reqN_valid (in, 1), reqN_ready (out, 1), reqN_write (in, 1), reqN_addr (in, ADDR_WIDTH), reqN_wdata (in, 32), reqN_byteen (in, 4), reqN_rvalid (out, 1) and reqN_rdata (out, 32).
REQ-006 SHALL have memory-side ports mem_en (out, 1), mem_write (out, 1), mem_addr (out, ADDR_WIDTH), mem_wdata (out, 32), mem_byteen (out, 4) and mem_rdata (in, 32, valid on the cycle after a read is issued).
REQ-007 SHALL have status ports owner (out, 1, the requester granted this cycle) and busy (out, 1, high whenever a grant is active this cycle).

Function
REQ-008 A beat is accepted on a cycle with reqN_valid and reqN_ready both high; at most one beat SHALL be accepted per cycle.
REQ-009 reqN_ready SHALL be combinational: high only for the selected requester, and only when its valid is high.
REQ-010 mem_en, mem_write, mem_addr, mem_wdata and mem_byteen SHALL be combinational copies of the selected requester's fields; mem_en equals the accept.
REQ-011 When mem_en is low, mem_write, mem_addr, mem_wdata and mem_byteen SHALL be driven to zero.
REQ-012 Selection FSM states: IDLE, OWN0, OWN1.
REQ-013 In IDLE with one valid, that requester SHALL be selected.
REQ-014 In IDLE with both valid, the requester not served last (the last_served register) SHALL be selected.
REQ-015 In OWNn, the owner SHALL stay selected while its valid is high, unless the hold rule (REQ-017) forces a switch.
REQ-016 In OWNn, if the owner's valid drops, the other requester SHALL be selected in that same cycle if it is valid; otherwise the FSM SHALL return to IDLE.
REQ-017 hold_count SHALL count consecutive beats accepted for the owner; when it equals MAX_HOLD and the other requester is valid, the other requester SHALL be selected that cycle.
REQ-018 hold_count SHALL reset to 1 on an ownership change and saturate at MAX_HOLD.
REQ-019 With only one requester active, it SHALL receive a beat every cycle indefinitely; the hold rule applies only under contention.
REQ-020 Every accepted read SHALL register the requester id into a one-deep return tag.
REQ-021 On the next cycle, reqT_rvalid SHALL pulse high for one cycle with reqT_rdata = mem_rdata; the other requester's rvalid SHALL stay low.
REQ-022 reqN_rdata SHALL be zero when reqN_rvalid is low.
REQ-023 Writes SHALL produce no rvalid.
REQ-024 Back-to-back reads from alternating requesters SHALL each return exactly one cycle after their own accept; the return path has no stall.
REQ-025 last_served SHALL update to the accepting requester on every accept.

Reset
REQ-026 While reset is high, the following SHALL be held regardless of clock: FSM=IDLE, hold_count=0, last_served=1 (so requester 0 wins the first contention), return tag invalid.
REQ-027 While reset is high, all outputs SHALL be 0.
REQ-028 Reset asserted mid-read SHALL suppress the pending rvalid, and no rvalid SHALL appear after deassertion.
REQ-029 The first accept SHALL be possible on the first rising edge after reset deassertion.

Structure
REQ-030 Package mem_port_arbiter_pkg SHALL hold the FSM state enum, the requester-id typedef, and a request struct (write, addr, wdata, byteen).
REQ-031 One sub-module, mem_port_arbiter_hold_counter, SHALL implement the saturating hold counter (inputs: clear, increment; output: at_limit).
REQ-032 The top SHALL contain the FSM, the selection mux, and the return tag.
REQ-033 Total RTL SHALL be 120-400 lines.

Verification
REQ-034 Reset release, then req0 read addr 0x010, req1 idle, mem_rdata 0xDEADBEEF -> req0_ready the same cycle; req0_rvalid the next cycle with 0xDEADBEEF; req1_rvalid stays 0.
REQ-035 Both requesters assert valid reads on the first post-reset cycle -> req0 granted first; beats alternate per REQ-016/017; each rvalid lands on the correct requester one cycle after its accept.
REQ-036 MAX_HOLD=4, req0 continuously valid, req1 raised on req0's 2nd beat -> req0 gets beats 1-4, req1 is granted on cycle 5, then req0 resumes after req1's 4th beat or when req1 drops.
REQ-037 req1 write addr 0x3FF, wdata 0x12345678, byteen 0b0011 -> mem_en=1, mem_write=1, fields match exactly; no rvalid on either requester.
REQ-038 Reset asserted the cycle after a req0 read accept -> req0_rvalid never pulses; all outputs 0 during reset; FSM is IDLE afterward.
REQ-039 req0 alone valid for 20 cycles with MAX_HOLD=8 -> 20 consecutive accepts with no gaps; busy=1 and owner=0 throughout.
